// File: rtl/student_fir_par_ctrl_pkg.sv
// Shared types and helpers for the segmented parallel FIR controller.
//   fir_par_state_e : controller FSM encoding
//   tree_levels(n)  : ceil(log2(n)), number of adder-tree levels
//   sat_signed(v,w) : clip a wide signed value into the signed w-bit range
package student_fir_par_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COLLECT = 3'd2,
    SUM     = 3'd3,
    OUT     = 3'd4
  } fir_par_state_e;

  function automatic int tree_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

  // Operates on a 128-bit carrier so a single helper serves every width.
  function automatic logic signed [127:0] sat_signed(input logic signed [127:0] value,
                                                     input int width);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/student_fir_par_adder_tree_pipe.sv
// Pipelined signed adder tree, one register stage per level.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   in_valid_i      : qualifies in_data_i, travels alongside the data
//   in_data_i       : NUM_IN packed signed operands of IN_WIDTH bits
//   out_valid_o     : result valid
//   out_data_o      : exact sum, IN_WIDTH + $clog2(NUM_IN) bits
// A single input degenerates to one pass-through register.
module student_fir_par_adder_tree_pipe
  import student_fir_par_ctrl_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int IN_WIDTH = 32,
  localparam int LVL     = tree_levels(NUM_IN),
  localparam int OW      = IN_WIDTH + LVL
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic [NUM_IN*IN_WIDTH-1:0] in_data_i,
  output logic                       out_valid_o,
  output logic [OW-1:0]              out_data_o
);

  localparam int STAGES = (LVL == 0) ? 1 : LVL;

  logic [NUM_IN-1:0][OW-1:0] ext;
  logic [STAGES-1:0]         vld_pipe;

  // Sign-extend once to the full output width; every later add is then exact.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      ext[i] = OW'($signed(in_data_i[i*IN_WIDTH +: IN_WIDTH]));
  end

  for (genvar l = 0; l < STAGES; l++) begin : g_lvl
    localparam int N = (LVL == 0) ? 1 : (NUM_IN >> (l + 1));
    logic [N-1:0][OW-1:0] d;
    logic [N-1:0][OW-1:0] q;

    if (LVL == 0) begin : g_pass
      assign d = ext;
    end else if (l == 0) begin : g_first
      always_comb begin
        for (int i = 0; i < N; i++) d[i] = ext[2*i] + ext[2*i+1];
      end
    end else begin : g_next
      always_comb begin
        for (int i = 0; i < N; i++) d[i] = g_lvl[l-1].q[2*i] + g_lvl[l-1].q[2*i+1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) q <= '0;
      else         q <= d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) vld_pipe <= '0;
    else         vld_pipe <= (vld_pipe << 1) | STAGES'(in_valid_i);
  end

  assign out_valid_o = vld_pipe[STAGES-1];
  assign out_data_o  = g_lvl[STAGES-1].q[0];

endmodule

// File: rtl/student_fir_par_ctrl.sv
// Sequencer/combiner for a segmented parallel FIR.
// Accepts one sample (valid/ready), pulses seg_start_o to all segments,
// captures each segment's first partial, sums them in a pipelined tree,
// then shifts, optionally rounds, saturates and presents the result
// (valid/ready). A COLLECT phase longer than TIMEOUT cycles aborts the
// frame and raises the sticky err_timeout_o.
// Build option: define STUDENT_FIR_PAR_CTRL_ROUND_EN for round-half-up
// before the shift; otherwise the shift truncates.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   sample_valid_i/ready_o, sample_i   input sample handshake
//   seg_start_o, seg_sample_o     start pulse and held sample to segments
//   seg_done_i, seg_y_i           per-segment strobes and packed partials
//   y_valid_o/y_ready_i, y_o, sat_o    result handshake and clip flag
//   busy_o, err_timeout_o, err_clr_i   status
module student_fir_par_ctrl
  import student_fir_par_ctrl_pkg::*;
#(
  parameter int NUM_SEG   = 4,
  parameter int DATA_SIZE = 16,
  parameter int SEG_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  input  logic [DATA_SIZE-1:0]         sample_i,
  output logic                         seg_start_o,
  output logic [DATA_SIZE-1:0]         seg_sample_o,
  input  logic [NUM_SEG-1:0]           seg_done_i,
  input  logic [NUM_SEG*SEG_WIDTH-1:0] seg_y_i,
  output logic                         y_valid_o,
  input  logic                         y_ready_i,
  output logic [OUT_WIDTH-1:0]         y_o,
  output logic                         sat_o,
  output logic                         busy_o,
  output logic                         err_timeout_o,
  input  logic                         err_clr_i
);

  localparam int LVL = tree_levels(NUM_SEG);
  localparam int SW  = SEG_WIDTH + LVL;
  localparam int TW  = $clog2(TIMEOUT + 1);
`ifdef STUDENT_FIR_PAR_CTRL_ROUND_EN
  localparam logic signed [SW:0] RND = (SHIFT > 0) ? ((SW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  fir_par_state_e                    state_q;
  logic [DATA_SIZE-1:0]              sample_q;
  logic [NUM_SEG-1:0][SEG_WIDTH-1:0] cap_q;
  logic [NUM_SEG-1:0]                done_q;
  logic [TW-1:0]                     timer_q;
  logic                              sum_go_q;
  logic [OUT_WIDTH-1:0]              y_q;
  logic                              sat_q;
  logic                              err_q;

  logic                    all_done, timeout_hit, tree_in_vld, tree_vld;
  logic [SW-1:0]           sum_w;
  logic signed [SW:0]      ext_w, shf_w;
  logic signed [127:0]     wide_w, clip_w;
  logic [OUT_WIDTH-1:0]    y_d;
  logic                    sat_d;

  assign all_done    = &done_q;
  // Completion wins over a timeout landing in the same cycle.
  assign timeout_hit = (state_q == COLLECT) && !all_done && (timer_q == TW'(TIMEOUT - 1));
  // With several levels the tree is launched on the first SUM cycle; the
  // single-register case launches one cycle earlier so total latency stays LVL+2.
  assign tree_in_vld = (LVL == 0) ? ((state_q == COLLECT) && all_done) : sum_go_q;

  student_fir_par_adder_tree_pipe #(
    .NUM_IN   (NUM_SEG),
    .IN_WIDTH (SEG_WIDTH)
  ) u_tree (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (tree_in_vld),
    .in_data_i   (cap_q),
    .out_valid_o (tree_vld),
    .out_data_o  (sum_w)
  );

  // Scale / round / saturate. One guard bit keeps the rounding add from wrapping.
  always_comb begin
    ext_w = {sum_w[SW-1], sum_w};
`ifdef STUDENT_FIR_PAR_CTRL_ROUND_EN
    ext_w = ext_w + RND;
`endif
    shf_w  = ext_w >>> SHIFT;
    wide_w = {{(127 - SW){shf_w[SW]}}, shf_w};
    clip_w = sat_signed(wide_w, OUT_WIDTH);
  end

  assign y_d   = clip_w[OUT_WIDTH-1:0];
  assign sat_d = (clip_w != wide_w);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sample_q <= '0;
      cap_q    <= '0;
      done_q   <= '0;
      timer_q  <= '0;
      sum_go_q <= 1'b0;
      y_q      <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sum_go_q <= 1'b0;
      if (timeout_hit)    err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sample_valid_i) begin
            sample_q <= sample_i;
            state_q  <= START;
          end
        end
        START: begin
          done_q  <= '0;
          timer_q <= '0;
          state_q <= COLLECT;
        end
        COLLECT: begin
          // Only the first strobe per segment is captured.
          for (int k = 0; k < NUM_SEG; k++)
            if (seg_done_i[k] && !done_q[k]) cap_q[k] <= seg_y_i[k*SEG_WIDTH +: SEG_WIDTH];
          done_q  <= done_q | seg_done_i;
          timer_q <= timer_q + TW'(1);
          if (all_done) begin
            state_q  <= SUM;
            sum_go_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= IDLE;
          end
        end
        SUM: begin
          if (tree_vld) begin
            y_q     <= y_d;
            sat_q   <= sat_d;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (y_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready_o = (state_q == IDLE);
  assign seg_start_o    = (state_q == START);
  assign seg_sample_o   = sample_q;
  assign y_valid_o      = (state_q == OUT);
  assign y_o            = y_q;
  assign sat_o          = sat_q;
  assign busy_o         = (state_q != IDLE);
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_student_fir_par_ctrl.sv
// Directed bench: two instances share all inputs; the first uses SHIFT=0,
// the second SHIFT=2, both OUT_WIDTH=16, TIMEOUT=8, four 32-bit segments.
module tb_student_fir_par_ctrl;

  logic clk = 1'b0;
  logic rst_n, sample_valid, y_ready, err_clr;
  logic [15:0] sample;
  logic [3:0]  seg_done;
  logic [3:0][31:0] seg_y;

  logic rdy_a, start_a, vld_a, sat_a, busy_a, err_a;
  logic rdy_b, start_b, vld_b, sat_b, busy_b, err_b;
  logic [15:0] ss_a, ss_b, y_a, y_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  student_fir_par_ctrl #(.NUM_SEG(4), .DATA_SIZE(16), .SEG_WIDTH(32), .OUT_WIDTH(16),
                         .SHIFT(0), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_valid_i(sample_valid), .sample_ready_o(rdy_a),
    .sample_i(sample), .seg_start_o(start_a), .seg_sample_o(ss_a), .seg_done_i(seg_done),
    .seg_y_i(seg_y), .y_valid_o(vld_a), .y_ready_i(y_ready), .y_o(y_a), .sat_o(sat_a),
    .busy_o(busy_a), .err_timeout_o(err_a), .err_clr_i(err_clr));

  student_fir_par_ctrl #(.NUM_SEG(4), .DATA_SIZE(16), .SEG_WIDTH(32), .OUT_WIDTH(16),
                         .SHIFT(2), .TIMEOUT(8)) u_dut_s2 (
    .clk_i(clk), .rst_ni(rst_n), .sample_valid_i(sample_valid), .sample_ready_o(rdy_b),
    .sample_i(sample), .seg_start_o(start_b), .seg_sample_o(ss_b), .seg_done_i(seg_done),
    .seg_y_i(seg_y), .y_valid_o(vld_b), .y_ready_i(y_ready), .y_o(y_b), .sat_o(sat_b),
    .busy_o(busy_b), .err_timeout_o(err_b), .err_clr_i(err_clr));

  typedef struct {
    logic [3:0][31:0] y;
    logic [15:0] e0;  logic es0;
    logic [15:0] e1r; logic [15:0] e1t; logic es1;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [31:0] a, b, c, d, input logic [15:0] e0,
                              input logic es0, input logic [15:0] e1r, e1t, input logic es1);
    vec_t v;
    v.y[0] = a; v.y[1] = b; v.y[2] = c; v.y[3] = d;
    v.e0 = e0; v.es0 = es0; v.e1r = e1r; v.e1t = e1t; v.es1 = es1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [15:0] s);
    int n;
    n = 0;
    while (!rdy_a && n < 20) begin tick(); n++; end
    chk("ready_wait", rdy_a, 1'b1);
    sample_valid = 1'b1; sample = s;
    tick();
    sample_valid = 1'b0;
  endtask

  // Called in START; advances to COLLECT and strobes every segment at once.
  task automatic collect_all(input logic [3:0][31:0] yv);
    tick();
    seg_y = yv; seg_done = 4'hF;
    tick();
    seg_done = 4'h0;
  endtask

  task automatic wait_out(output logic got);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (vld_a && vld_b) got = 1'b1;
      else tick();
    end
    chk("out_wait", got, 1'b1);
  endtask

  task automatic handshake();
    y_ready = 1'b1; tick(); y_ready = 1'b0;
  endtask

  task automatic do_frame(input logic [3:0][31:0] yv, output logic [15:0] r0,
                          output logic s0, output logic [15:0] r1, output logic s1);
    logic got;
    accept(16'h00A5);
    collect_all(yv);
    wait_out(got);
    r0 = y_a; s0 = sat_a; r1 = y_b; s1 = sat_b;
    handshake();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r0, r1, e1;
    logic s0, s1, got, seen;
    logic [3:0][31:0] yv;
    int lat;

    tbl[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 16'd10, 0, 16'd3, 16'd2, 0);
    tbl[1] = mk(32'h7000, 32'h7000, 32'h7000, 32'h7000, 16'h7FFF, 1, 16'h7000, 16'h7000, 0);
    tbl[2] = mk(32'hFFFF9000, 32'hFFFF9000, 32'hFFFF9000, 32'hFFFF9000, 16'h8000, 1, 16'h9000, 16'h9000, 0);
    tbl[3] = mk(32'd6, 32'd0, 32'd0, 32'd0, 16'd6, 0, 16'd2, 16'd1, 0);
    tbl[4] = mk(32'hFFFFFFFA, 32'd0, 32'd0, 32'd0, 16'hFFFA, 0, 16'hFFFF, 16'hFFFE, 0);
    tbl[5] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'h7FFF, 1, 16'h7FFF, 16'h7FFF, 1);
    tbl[6] = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 16'h8000, 1, 16'h8000, 16'h8000, 1);
    tbl[7] = mk(32'h7FFF, 32'd0, 32'd0, 32'd0, 16'h7FFF, 0, 16'h2000, 16'h1FFF, 0);
    tbl[8] = mk(32'hFFFF8000, 32'd0, 32'd0, 32'd0, 16'h8000, 0, 16'hE000, 16'hE000, 0);
    tbl[9] = mk(32'h8000, 32'd0, 32'd0, 32'd0, 16'h7FFF, 1, 16'h2000, 16'h2000, 0);

    rst_n = 1'b0; sample_valid = 1'b0; sample = '0; seg_done = '0; seg_y = '0;
    y_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_start", start_a, 1'b0);
    chk("rst_valid", vld_a, 1'b0);
    chk("rst_y", y_a, 16'h0);
    chk("rst_err", err_a, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table: all segments done together, both shift settings checked.
    for (int i = 0; i < 10; i++) begin
`ifdef STUDENT_FIR_PAR_CTRL_ROUND_EN
      e1 = tbl[i].e1r;
`else
      e1 = tbl[i].e1t;
`endif
      do_frame(tbl[i].y, r0, s0, r1, s1);
      chk($sformatf("tbl%0d_y", i), r0, tbl[i].e0);
      chk($sformatf("tbl%0d_sat", i), s0, tbl[i].es0);
      chk($sformatf("tbl%0d_y_s2", i), r1, e1);
      chk($sformatf("tbl%0d_sat_s2", i), s1, tbl[i].es1);
    end

    // Out-of-order completion, duplicate strobe, simultaneous strobes, latency.
    accept(16'h1234);
    chk("t1_start", start_a, 1'b1);
    chk("t1_sample", ss_a, 16'h1234);
    tick();
    chk("t1_start_once", start_a, 1'b0);
    seg_y = '0; seg_y[3] = 32'd4; seg_done = 4'b1000; tick();
    seg_y[0] = 32'd1; seg_done = 4'b0001; tick();
    seg_y[3] = 32'd99; seg_y[2] = 32'd3; seg_done = 4'b1100; tick();
    seg_y[1] = 32'd2; seg_done = 4'b0010; tick();
    seg_done = 4'b0000;
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (vld_a) lat = n;
    end
    chk("t1_latency", lat, 4);
    chk("t1_y", y_a, 16'd10);
    chk("t1_sat", sat_a, 1'b0);
    handshake();

    // Back-pressure in OUT: result held, new sample refused until handshake.
    accept(16'h0111);
    yv[0] = 32'd1; yv[1] = 32'd1; yv[2] = 32'd1; yv[3] = 32'd1;
    collect_all(yv);
    wait_out(got);
    sample_valid = 1'b1; sample = 16'h0222;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_valid_hold", vld_a, 1'b1);
      chk("t3_y_hold", y_a, 16'd4);
      chk("t3_sat_hold", sat_a, 1'b0);
      chk("t3_ready_low", rdy_a, 1'b0);
      chk("t3_sample_kept", ss_a, 16'h0111);
    end
    handshake();
    chk("t3_ready_after", rdy_a, 1'b1);
    tick();
    sample_valid = 1'b0;
    chk("t3_accept_start", start_a, 1'b1);
    chk("t3_accept_sample", ss_a, 16'h0222);
    yv[0] = 32'd7; yv[1] = 32'd0; yv[2] = 32'd0; yv[3] = 32'd0;
    collect_all(yv);
    wait_out(got);
    chk("t3_second_y", y_a, 16'd7);
    handshake();

    // Timeout with segment 3 missing, then clear.
    accept(16'h0333);
    tick();
    seg_y = '0; seg_done = 4'b0111; tick();
    seg_done = 4'b0000;
    seen = 1'b0;
    for (int e = 2; e <= 8; e++) begin
      tick();
      if (vld_a) seen = 1'b1;
      if (e == 7) chk("t4_err_early", err_a, 1'b0);
    end
    chk("t4_err_set", err_a, 1'b1);
    chk("t4_err_set_s2", err_b, 1'b1);
    chk("t4_idle", busy_a, 1'b0);
    chk("t4_no_valid", seen, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_err_clr", err_a, 1'b0);

    // Timeout coinciding with a held clear: timeout wins that cycle.
    err_clr = 1'b1;
    accept(16'h0444);
    tick();
    seg_done = 4'b0001; tick();
    seg_done = 4'b0000;
    for (int e = 2; e <= 8; e++) tick();
    chk("t4_prio", err_a, 1'b1);
    tick();
    chk("t4_prio_clr", err_a, 1'b0);
    err_clr = 1'b0;

    // Reset mid-COLLECT discards the frame.
    accept(16'h0555);
    tick();
    seg_y = '0; seg_y[0] = 32'd9; seg_done = 4'b0001; tick();
    seg_done = 4'b0000;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_ready", rdy_a, 1'b1);
    chk("t6_busy", busy_a, 1'b0);
    chk("t6_valid", vld_a, 1'b0);
    chk("t6_start", start_a, 1'b0);
    chk("t6_y", y_a, 16'h0);
    chk("t6_sat", sat_a, 1'b0);
    chk("t6_sample", ss_a, 16'h0);
    chk("t6_err", err_a, 1'b0);
    yv[0] = 32'd5; yv[1] = 32'd5; yv[2] = 32'd5; yv[3] = 32'd5;
    do_frame(yv, r0, s0, r1, s1);
    chk("t6_y_after", r0, 16'd20);
    chk("t6_sat_after", s0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
